// File: rtl/primal_op_sequencer_if.sv
// Bundle of request, engine and response signals for the primal op sequencer.
// The sequencer takes the slave view; its environment (requester, engine, consumer) the master view.
interface primal_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic [31:0] eng_prime_a;
    logic [31:0] eng_prime_b;
    logic [1:0]  eng_op;
    logic        eng_compute;
    logic [31:0] eng_result;
    logic [31:0] eng_t1_remainder;
    logic        eng_valid;
    logic        eng_violation;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [7:0]  rsp_remain_a;
    logic [7:0]  rsp_remain_b;
    logic [1:0]  rsp_op;
    logic        rsp_violation;
    logic        rsp_format_err;
    logic        rsp_timeout;

    logic        busy;
    logic [15:0] seq_count;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  eng_result, eng_t1_remainder, eng_valid, eng_violation,
        input  rsp_ready,
        output req_ready,
        output eng_prime_a, eng_prime_b, eng_op, eng_compute,
        output rsp_valid, rsp_result, rsp_remain_a, rsp_remain_b, rsp_op,
        output rsp_violation, rsp_format_err, rsp_timeout,
        output busy, seq_count
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output eng_result, eng_t1_remainder, eng_valid, eng_violation,
        output rsp_ready,
        input  req_ready,
        input  eng_prime_a, eng_prime_b, eng_op, eng_compute,
        input  rsp_valid, rsp_result, rsp_remain_a, rsp_remain_b, rsp_op,
        input  rsp_violation, rsp_format_err, rsp_timeout,
        input  busy, seq_count
    );
endinterface

// File: rtl/primal_op_sequencer.sv
// Initiator-side driver for the primal math engine: buffers requests in a FIFO, launches
// each one, waits out the helical latency and returns the captured, unpacked result.
module primal_op_sequencer #(
    parameter int DEPTH          = 4,
    parameter int BREATH_CYCLES  = 20,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    primal_op_sequencer_if.slave  bus
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int WAIT_MAX = (BREATH_CYCLES > TIMEOUT_CYCLES) ? BREATH_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W    = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, BREATHE, CHECK, RESPOND} state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    req_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    req_t             head;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [1:0]       cur_op;

    // Ready looks only at the registered count, so a full FIFO refuses even while popping.
    assign bus.req_ready = (count != CNT_W'(DEPTH));
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = (state == IDLE) && (count != '0);
    assign head          = fifo_mem[rd_ptr];
    assign bus.busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{op: bus.req_op, a: bus.req_a, b: bus.req_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            timer              <= '0;
            cur_op             <= '0;
            bus.eng_prime_a    <= '0;
            bus.eng_prime_b    <= '0;
            bus.eng_op         <= '0;
            bus.eng_compute    <= 1'b0;
            bus.rsp_valid      <= 1'b0;
            bus.rsp_result     <= '0;
            bus.rsp_remain_a   <= '0;
            bus.rsp_remain_b   <= '0;
            bus.rsp_op         <= '0;
            bus.rsp_violation  <= 1'b0;
            bus.rsp_format_err <= 1'b0;
            bus.rsp_timeout    <= 1'b0;
            bus.seq_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.eng_prime_a <= head.a;
                        bus.eng_prime_b <= head.b;
                        bus.eng_op      <= head.op;
                        cur_op          <= head.op;
                        bus.eng_compute <= 1'b1;
                        state           <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    bus.eng_compute <= 1'b0;
                    timer           <= '0;
                    state           <= BREATHE;
                end
                BREATHE: begin
                    if (timer == TMR_W'(BREATH_CYCLES - 1)) begin
                        timer <= '0;
                        state <= CHECK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CHECK: begin
                    // A valid result on the final counted cycle still wins over the timeout.
                    if (bus.eng_valid) begin
                        bus.rsp_result     <= bus.eng_result;
                        bus.rsp_remain_a   <= bus.eng_t1_remainder[23:16];
                        bus.rsp_remain_b   <= bus.eng_t1_remainder[31:24];
                        bus.rsp_violation  <= bus.eng_violation;
                        bus.rsp_format_err <= |bus.eng_t1_remainder[15:0];
                        bus.rsp_timeout    <= 1'b0;
                        bus.rsp_op         <= cur_op;
                        bus.rsp_valid      <= 1'b1;
                        state              <= RESPOND;
                    end else if (timer == TMR_W'(TIMEOUT_CYCLES)) begin
                        bus.rsp_result     <= '0;
                        bus.rsp_remain_a   <= '0;
                        bus.rsp_remain_b   <= '0;
                        bus.rsp_violation  <= 1'b0;
                        bus.rsp_format_err <= 1'b0;
                        bus.rsp_timeout    <= 1'b1;
                        bus.rsp_op         <= cur_op;
                        bus.rsp_valid      <= 1'b1;
                        state              <= RESPOND;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESPOND: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.seq_count <= bus.seq_count + 16'd1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_primal_op_sequencer.sv
// Scoreboard bench for primal_op_sequencer: directed requests push hand-computed responses,
// a negedge monitor checks each response handshake, launch pulse and response timing.
module tb_primal_op_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    primal_op_sequencer_if bus ();

    primal_op_sequencer #(
        .DEPTH(4),
        .BREATH_CYCLES(20),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        viol;
        logic        fmt;
        logic        tmo;
        int          rise;
    } exp_t;

    exp_t sb[$];
    int   assertions = 0;
    int   failures   = 0;
    int   cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        assertions++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic exp_t mkExp(input logic [31:0] result, input logic [7:0] ra, input logic [7:0] rb,
                                   input logic viol, input logic fmt, input logic tmo);
        exp_t e;
        e.op = '0; e.a = '0; e.b = '0; e.rise = -1;
        e.result = result; e.ra = ra; e.rb = rb;
        e.viol = viol; e.fmt = fmt; e.tmo = tmo;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input exp_t e, input int rise_off);
        int budget = 200;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        while (!bus.req_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        checkOutput("req_accept", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        e.op = op; e.a = a; e.b = b;
        e.rise = (rise_off < 0) ? -1 : cyc + rise_off;
        sb.push_back(e);
    endtask

    task automatic waitDrain(input int budget);
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        checkOutput("drain_pending", sb.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic waitRspValid(input int budget);
        while (!bus.rsp_valid && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        checkOutput("rsp_valid_wait", {31'b0, bus.rsp_valid}, 32'd1);
    endtask

    // Monitor: response timing, response contents on handshake, launch pulse shape and operands.
    logic prev_valid   = 1'b0;
    logic prev_compute = 1'b0;
    int   comp_width   = 0;
    int   exp_seq      = 0;
    exp_t got;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid   = 1'b0;
            prev_compute = 1'b0;
            comp_width   = 0;
            exp_seq      = 0;
        end else begin
            if (bus.rsp_valid && !prev_valid) begin
                if (sb.size() == 0) checkOutput("unexpected_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
                else if (sb[0].rise >= 0) checkOutput("rsp_rise_cycle", cyc, sb[0].rise);
            end
            if (bus.rsp_valid && bus.rsp_ready && sb.size() > 0) begin
                got = sb.pop_front();
                checkOutput("rsp_op",         {30'b0, bus.rsp_op},       {30'b0, got.op});
                checkOutput("rsp_result",     bus.rsp_result,            got.result);
                checkOutput("rsp_remain_a",   {24'b0, bus.rsp_remain_a}, {24'b0, got.ra});
                checkOutput("rsp_remain_b",   {24'b0, bus.rsp_remain_b}, {24'b0, got.rb});
                checkOutput("rsp_violation",  {31'b0, bus.rsp_violation},  {31'b0, got.viol});
                checkOutput("rsp_format_err", {31'b0, bus.rsp_format_err}, {31'b0, got.fmt});
                checkOutput("rsp_timeout",    {31'b0, bus.rsp_timeout},    {31'b0, got.tmo});
                checkOutput("seq_count_at_hs", {16'b0, bus.seq_count}, exp_seq & 32'hFFFF);
                exp_seq++;
            end
            if (bus.eng_compute) begin
                if (!prev_compute && sb.size() > 0) begin
                    checkOutput("eng_op",      {30'b0, bus.eng_op}, {30'b0, sb[0].op});
                    checkOutput("eng_prime_a", bus.eng_prime_a, sb[0].a);
                    checkOutput("eng_prime_b", bus.eng_prime_b, sb[0].b);
                end
                comp_width++;
            end else if (prev_compute) begin
                checkOutput("compute_width", comp_width, 32'd1);
                comp_width = 0;
            end
            prev_valid   = bus.rsp_valid;
            prev_compute = bus.eng_compute;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"},   {31'b0, bus.req_ready},   32'd1);
        checkOutput({tag, "_rsp_valid"},   {31'b0, bus.rsp_valid},   32'd0);
        checkOutput({tag, "_eng_compute"}, {31'b0, bus.eng_compute}, 32'd0);
        checkOutput({tag, "_busy"},        {31'b0, bus.busy},        32'd0);
        checkOutput({tag, "_eng_op"},      {30'b0, bus.eng_op},      32'd0);
        checkOutput({tag, "_eng_prime_a"}, bus.eng_prime_a,          32'd0);
        checkOutput({tag, "_eng_prime_b"}, bus.eng_prime_b,          32'd0);
        checkOutput({tag, "_rsp_result"},  bus.rsp_result,           32'd0);
        checkOutput({tag, "_rsp_flags"},
                    {29'b0, bus.rsp_violation, bus.rsp_format_err, bus.rsp_timeout}, 32'd0);
        checkOutput({tag, "_rsp_remains"}, {14'b0, bus.rsp_op, bus.rsp_remain_b, bus.rsp_remain_a}, 32'd0);
        checkOutput({tag, "_seq_count"},   {16'b0, bus.seq_count},   32'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        bus.rsp_ready = 1'b0;
        bus.eng_result = '0; bus.eng_t1_remainder = '0;
        bus.eng_valid = 1'b0; bus.eng_violation = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] single ADD");
        bus.eng_result = 32'd6; bus.eng_t1_remainder = 32'h0503_0000;
        bus.eng_valid = 1'b1; bus.rsp_ready = 1'b1;
        applyStimulus(2'b00, 32'd3, 32'd5, mkExp(32'd6, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0), 23);
        checkOutput("busy_after_accept", {31'b0, bus.busy}, 32'd1);
        waitDrain(100);
        checkOutput("seq_count_add", {16'b0, bus.seq_count}, 32'd1);
        checkOutput("busy_idle_add", {31'b0, bus.busy}, 32'd0);

        $display("[TB] timeout");
        bus.eng_valid = 1'b0; bus.eng_result = 32'hDEAD_BEEF; bus.eng_t1_remainder = 32'h1122_0000;
        applyStimulus(2'b01, 32'd7, 32'd11, mkExp(32'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1), 87);
        waitDrain(200);
        checkOutput("seq_count_tmo", {16'b0, bus.seq_count}, 32'd2);

        $display("[TB] format and violation");
        bus.eng_valid = 1'b1; bus.eng_result = 32'h0000_1234;
        bus.eng_t1_remainder = 32'h0102_0004; bus.eng_violation = 1'b1;
        applyStimulus(2'b10, 32'd19, 32'd23, mkExp(32'h1234, 8'h02, 8'h01, 1'b1, 1'b1, 1'b0), 23);
        waitDrain(100);
        bus.eng_violation = 1'b0;

        $display("[TB] backpressure");
        bus.rsp_ready = 1'b0; bus.eng_result = 32'h0000_ABCD; bus.eng_t1_remainder = 32'h110D_0000;
        applyStimulus(2'b11, 32'd13, 32'd17, mkExp(32'hABCD, 8'h0D, 8'h11, 1'b0, 1'b0, 1'b0), 23);
        waitRspValid(100);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_rsp_valid",  {31'b0, bus.rsp_valid}, 32'd1);
            checkOutput("bp_rsp_result", bus.rsp_result, 32'h0000_ABCD);
            checkOutput("bp_rsp_remain", {16'b0, bus.rsp_remain_b, bus.rsp_remain_a}, 32'h0000_110D);
            checkOutput("bp_rsp_op",     {30'b0, bus.rsp_op}, 32'd3);
            checkOutput("bp_seq_count",  {16'b0, bus.seq_count}, 32'd3);
        end
        bus.rsp_ready = 1'b1;
        waitDrain(20);
        checkOutput("seq_count_bp", {16'b0, bus.seq_count}, 32'd4);

        $display("[TB] FIFO full");
        bus.rsp_ready = 1'b0; bus.eng_result = 32'h0000_0042; bus.eng_t1_remainder = 32'h0907_0000;
        applyStimulus(2'b00, 32'd101, 32'd103, mkExp(32'h42, 8'h07, 8'h09, 1'b0, 1'b0, 1'b0), 23);
        applyStimulus(2'b01, 32'd107, 32'd109, mkExp(32'h42, 8'h07, 8'h09, 1'b0, 1'b0, 1'b0), -1);
        applyStimulus(2'b10, 32'd113, 32'd127, mkExp(32'h42, 8'h07, 8'h09, 1'b0, 1'b0, 1'b0), -1);
        applyStimulus(2'b11, 32'd131, 32'd137, mkExp(32'h42, 8'h07, 8'h09, 1'b0, 1'b0, 1'b0), -1);
        applyStimulus(2'b00, 32'd139, 32'd149, mkExp(32'h42, 8'h07, 8'h09, 1'b0, 1'b0, 1'b0), -1);
        waitRspValid(100);
        checkOutput("full_req_ready", {31'b0, bus.req_ready}, 32'd0);
        bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_a = 32'd151; bus.req_b = 32'd157;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("full_still_blocked", {31'b0, bus.req_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("full_refuses_during_pop", {31'b0, bus.req_ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("ready_after_pop", {31'b0, bus.req_ready}, 32'd1);
        applyStimulus(2'b01, 32'd151, 32'd157, mkExp(32'h42, 8'h07, 8'h09, 1'b0, 1'b0, 1'b0), -1);
        waitDrain(300);
        checkOutput("seq_count_fifo", {16'b0, bus.seq_count}, 32'd10);

        $display("[TB] reset mid-BREATHE");
        applyStimulus(2'b10, 32'd163, 32'd167, mkExp(32'h42, 8'h07, 8'h09, 1'b0, 1'b0, 1'b0), -1);
        applyStimulus(2'b11, 32'd173, 32'd179, mkExp(32'h42, 8'h07, 8'h09, 1'b0, 1'b0, 1'b0), -1);
        applyStimulus(2'b00, 32'd181, 32'd191, mkExp(32'h42, 8'h07, 8'h09, 1'b0, 1'b0, 1'b0), -1);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkResetValues("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        checkOutput("post_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        checkOutput("post_rst_busy",      {31'b0, bus.busy},      32'd0);
        checkOutput("post_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        checkOutput("post_rst_seq_count", {16'b0, bus.seq_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
